// File: rtl/testing_wb_slave.sv
`default_nettype none
// ============================================================================
// Module   : testing_wb_slave
// Purpose  : Wishbone classic-cycle target with a byte-addressable register
//            file. The number of wait states and retry injection are set at
//            run time. Accesses outside the decoded window end with an error.
// Ports    : wb_clk, wb_rst_n      - bus clock, async active-low reset
//            wb_adr_i/dat_i/sel_i  - byte address, write data, lane enables
//            wb_we_i/cyc_i/stb_i   - direction, cycle, strobe
//            wb_cti_i/bte_i        - burst tags (accepted, ignored)
//            wb_dat_o              - read data (registered)
//            wb_ack_o/err_o/rty_o  - one-cycle terminations (registered)
//            wait_cycles           - wait states, sampled at acceptance
//            rty_inject            - force retry, sampled at acceptance
//            access_count          - saturating count of acked accesses
// Revision : 1.0 - initial release
// ============================================================================
module testing_wb_slave #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter logic [aw-1:0] BASE_ADDR = '0
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  input  logic [3:0]    wait_cycles,
  input  logic          rty_inject,
  output logic [15:0]   access_count
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;
  // Address bits below this boundary select a word/byte inside the window.
  localparam logic [aw-1:0] c_WIN_MASK = ~(aw'(4 * c_DEPTH - 1));

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [3:0]            r_wcnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [dw-1:0]         r_dat;
  logic                  r_in_range;
  logic                  r_rty_req;
  logic [dw-1:0]         r_mem [c_DEPTH];

  logic [dw-1:0]         r_dat_o;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_rty;
  logic [15:0]           r_count;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic                  w_req;
  logic                  w_in_range_live;
  logic                  w_idle;
  logic [DEPTH_LOG2-1:0] w_eff_idx;
  logic                  w_eff_we;
  logic [3:0]            w_eff_sel;
  logic [dw-1:0]         w_eff_dat;
  logic                  w_eff_in_range;
  logic                  w_eff_rty;
  logic                  w_respond;
  logic                  w_do_ack;
  logic                  w_do_err;
  logic                  w_do_rty;
  logic [dw-1:0]         w_rd_word;
  logic                  w_unused_ok;

  assign w_req           = wb_cyc_i & wb_stb_i;
  assign w_in_range_live = (wb_adr_i & c_WIN_MASK) == BASE_ADDR;
  assign w_idle          = (r_state == c_IDLE);

  // A zero-wait access terminates on the same edge that accepts it, so the
  // response is formed from the live bus; otherwise from the latched copy.
  assign w_eff_idx      = w_idle ? wb_adr_i[DEPTH_LOG2+1:2] : r_idx;
  assign w_eff_we       = w_idle ? wb_we_i         : r_we;
  assign w_eff_sel      = w_idle ? wb_sel_i        : r_sel;
  assign w_eff_dat      = w_idle ? wb_dat_i        : r_dat;
  assign w_eff_in_range = w_idle ? w_in_range_live : r_in_range;
  assign w_eff_rty      = w_idle ? rty_inject      : r_rty_req;

  // Dropping cyc/stb on the final wait edge still aborts the access.
  assign w_respond = w_req &
                     ((w_idle && (wait_cycles == 4'd0)) ||
                      ((r_state == c_WAIT) && (r_wcnt == 4'd1)));

  // Termination priority: err > rty > ack.
  assign w_do_err = w_respond & ~w_eff_in_range;
  assign w_do_rty = w_respond &  w_eff_in_range &  w_eff_rty;
  assign w_do_ack = w_respond &  w_eff_in_range & ~w_eff_rty;

  assign w_rd_word = r_mem[w_eff_idx];

  // Burst tags play no part in the single-access protocol.
  assign w_unused_ok = ^{wb_cti_i, wb_bte_i};

  // --------------------------------------------------------------------------
  // Control FSM and request latch
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= c_IDLE;
      r_wcnt     <= 4'd0;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_sel      <= 4'd0;
      r_dat      <= '0;
      r_in_range <= 1'b0;
      r_rty_req  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_req) begin
            r_idx      <= wb_adr_i[DEPTH_LOG2+1:2];
            r_we       <= wb_we_i;
            r_sel      <= wb_sel_i;
            r_dat      <= wb_dat_i;
            r_in_range <= w_in_range_live;
            r_rty_req  <= rty_inject;
            r_wcnt     <= wait_cycles;
            r_state    <= (wait_cycles != 4'd0) ? c_WAIT : c_RESP;
          end
        end
        c_WAIT: begin
          if (!w_req) begin
            r_state <= c_IDLE;
          end else if (r_wcnt == 4'd1) begin
            r_state <= c_RESP;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file: lane-masked write on an acked write only
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_ack && w_eff_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_eff_sel[b]) begin
          r_mem[w_eff_idx][8*b +: 8] <= w_eff_dat[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered responses; every non-response cycle returns them to zero
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_dat_o <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_count <= 16'd0;
    end else begin
      r_ack   <= w_do_ack;
      r_err   <= w_do_err;
      r_rty   <= w_do_rty;
      r_dat_o <= (w_do_ack && !w_eff_we) ? w_rd_word : '0;
      if (w_do_ack && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign wb_dat_o     = r_dat_o;
  assign wb_ack_o     = r_ack;
  assign wb_err_o     = r_err;
  assign wb_rty_o     = r_rty;
  assign access_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_testing_wb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_testing_wb_slave
// Purpose  : Self-checking bench for testing_wb_slave. A driver issues bus
//            accesses and queues the expected termination computed from a
//            word-array model; a monitor pops and compares on each
//            termination it observes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_testing_wb_slave;

  localparam logic [31:0] c_BASE = 32'h0000_1000;
  localparam int          c_WORDS = 16;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic [3:0]  wait_cycles = '0;
  logic        rty_inject = 1'b0;
  logic [15:0] access_count;

  testing_wb_slave #(
    .dw(32), .aw(32), .DEPTH_LOG2(4), .BASE_ADDR(c_BASE)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o), .wait_cycles(wait_cycles),
    .rty_inject(rty_inject), .access_count(access_count)
  );

  always #5 wb_clk = ~wb_clk;

  int unsigned cyc = 0;
  always @(posedge wb_clk) cyc++;

  // kind is {err, rty, ack}
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
    bit          chk_data;
    int unsigned t0;
    int unsigned lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_terms = 0;

  logic [31:0] mem_m [c_WORDS];
  int          count_m = 0;

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge wb_clk) begin
    if (wb_rst_n && (wb_ack_o || wb_err_o || wb_rty_o)) begin
      exp_t        e;
      logic [2:0]  k;
      int unsigned lat;
      k = {wb_err_o, wb_rty_o, wb_ack_o};
      n_terms++;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_term: got kind=%b, none expected (t=%0t)", k, $time);
      end else begin
        e = sbq.pop_front();
        lat = cyc - e.t0;
        if (k !== e.kind || lat != e.lat || (e.chk_data && wb_dat_o !== e.data)) begin
          n_bad++;
          $display("FAIL termination: kind got %b exp %b, latency got %0d exp %0d, data got %h exp %h",
                   k, e.kind, lat, e.lat, wb_dat_o, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= c_BASE) && (a < c_BASE + 32'd64);
  endfunction

  task automatic drive(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [3:0] w, input logic rty);
    wb_adr_i    = adr;
    wb_we_i     = we;
    wb_dat_i    = dat;
    wb_sel_i    = sel;
    wait_cycles = w;
    rty_inject  = rty;
    wb_cti_i    = 3'($urandom);
    wb_bte_i    = 2'($urandom);
    wb_cyc_i    = 1'b1;
    wb_stb_i    = 1'b1;
  endtask

  // One complete access with its expected outcome queued for the monitor.
  task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [3:0] w, input logic rty);
    exp_t e;
    int   idx;
    int   seen;
    int   k;
    @(posedge wb_clk); #1;
    e.t0 = cyc;
    e.lat = 32'(w) + 1;
    e.data = '0;
    e.chk_data = 1'b1;
    if (!in_win(adr)) begin
      e.kind = 3'b100;
    end else if (rty) begin
      e.kind = 3'b010;
    end else begin
      e.kind = 3'b001;
      idx = int'((adr - c_BASE) >> 2);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem_m[idx][8*b +: 8] = dat[8*b +: 8];
        e.chk_data = 1'b0;
      end else begin
        e.data = mem_m[idx];
      end
      if (count_m < 65535) count_m++;
    end
    sbq.push_back(e);
    seen = n_terms;
    drive(adr, we, dat, sel, w, rty);
    @(posedge wb_clk); #1;
    // Once accepted, these must no longer influence the access.
    wait_cycles = 4'($urandom);
    rty_inject  = 1'($urandom);
    k = 0;
    while (n_terms == seen && k < 40) begin
      @(negedge wb_clk); #1;
      k++;
    end
    if (n_terms == seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no termination for adr %h within 40 cycles", adr);
      sbq.delete();
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    chk("access_count", {16'd0, access_count}, 32'(count_m));
  endtask

  // Access dropped after 'hold' edges while still waiting: no effect at all.
  task automatic abort_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                              input logic [3:0] w, input int hold);
    @(posedge wb_clk); #1;
    drive(adr, we, dat, 4'hF, w, 1'b0);
    repeat (hold) @(posedge wb_clk);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (int'(w) + 3) @(posedge wb_clk);
    #1;
    chk("abort_count", {16'd0, access_count}, 32'(count_m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr;
    logic [3:0]  w;
    for (int i = 0; i < c_WORDS; i++) mem_m[i] = '0;

    // Reset state
    repeat (3) @(posedge wb_clk);
    #1;
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'h0);
    chk("rst_err", {31'd0, wb_err_o}, 32'h0);
    chk("rst_rty", {31'd0, wb_rty_o}, 32'h0);
    chk("rst_count", {16'd0, access_count}, 32'h0);
    wb_rst_n = 1'b1;

    // Full-word write then read back
    access(c_BASE + 32'd12, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'd0, 1'b0);
    access(c_BASE + 32'd12, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0);

    // Partial-lane write over all-ones
    access(c_BASE + 32'd20, 1'b1, 32'hFFFF_FFFF, 4'hF, 4'd0, 1'b0);
    access(c_BASE + 32'd20, 1'b1, 32'h1122_3344, 4'b0101, 4'd0, 1'b0);
    access(c_BASE + 32'd20, 1'b0, 32'h0, 4'hF, 4'd1, 1'b0);

    // Wait states, then an abandoned access, then a normal one
    access(c_BASE + 32'd12, 1'b0, 32'h0, 4'hF, 4'd5, 1'b0);
    abort_access(c_BASE + 32'd12, 1'b1, 32'h0BAD_0BAD, 4'd5, 3);
    access(c_BASE + 32'd12, 1'b0, 32'h0, 4'hF, 4'd2, 1'b0);

    // Out of window: error wins over retry; no aliasing write to word 0
    access(c_BASE + 32'h40, 1'b1, 32'h1234_5678, 4'hF, 4'd0, 1'b0);
    access(c_BASE + 32'h40, 1'b0, 32'h0, 4'hF, 4'd1, 1'b1);
    access(c_BASE + 32'd0, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0);

    // Retry leaves the word alone; the repeat succeeds
    access(c_BASE + 32'd28, 1'b1, 32'h5A5A_5A5A, 4'hF, 4'd2, 1'b1);
    access(c_BASE + 32'd28, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0);
    access(c_BASE + 32'd28, 1'b1, 32'h5A5A_5A5A, 4'hF, 4'd0, 1'b0);
    access(c_BASE + 32'd28, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0);

    // Empty lane mask: acked and counted, word unchanged
    access(c_BASE + 32'd13, 1'b1, 32'h0000_0000, 4'h0, 4'd0, 1'b0);
    access(c_BASE + 32'd15, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0);

    // Reset asserted while a write is waiting
    @(posedge wb_clk); #1;
    drive(c_BASE + 32'd36, 1'b1, 32'hCAFE_F00D, 4'hF, 4'd4, 1'b0);
    repeat (2) @(posedge wb_clk);
    #3;
    wb_rst_n = 1'b0;
    #1;
    chk("midrst_dat", wb_dat_o, 32'h0);
    chk("midrst_term", {29'd0, wb_err_o, wb_rty_o, wb_ack_o}, 32'h0);
    chk("midrst_count", {16'd0, access_count}, 32'h0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    for (int i = 0; i < c_WORDS; i++) mem_m[i] = '0;
    count_m = 0;
    @(posedge wb_clk); #2;
    wb_rst_n = 1'b1;
    access(c_BASE + 32'd36, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0);
    access(c_BASE + 32'd12, 1'b0, 32'h0, 4'hF, 4'd3, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) adr = $urandom;
      else adr = c_BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      w = 4'($urandom_range(0, 3));
      if (w >= 4'd2 && $urandom_range(0, 9) == 0)
        abort_access(adr, 1'($urandom), $urandom, w, $urandom_range(1, int'(w) - 1));
      else
        access(adr, 1'($urandom), $urandom, 4'($urandom), w, ($urandom_range(0, 5) == 0));
    end

    repeat (5) @(posedge wb_clk);
    #1;
    chk("final_queue_empty", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/testing_wb_slave.md
Name: testing_wb_slave

Overview:
- Wishbone classic-cycle responder: a small byte-addressable register file with runtime-programmable wait states and retry injection.
- Address-range errors return wb_err_o.
- Serves as the target end of the bus for exercising the bus-master test block and the DSP masters in simulation and on FPGA.
- Responds to single reads and writes only; burst tags are accepted but ignored.

Parameters:
- dw, 32, data width; fixed 32 in this revision, 4 byte lanes.
- aw, 32, address width.
- DEPTH_LOG2, 4, log2 of word count; the register file holds 2**DEPTH_LOG2 words.
- BASE_ADDR, 32'h0000_0000, base of the decoded window; must be aligned to 4*2**DEPTH_LOG2.

Ports:
- wb_clk  in  1  bus clock; all state changes on its rising edge.
- wb_rst_n  in  1  reset, asynchronous assert, active-low.
- wb_adr_i  in  aw  byte address.
- wb_dat_i  in  dw  write data.
- wb_sel_i  in  4  byte lane enables.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type; ignored.
- wb_bte_i  in  2  burst type; ignored.
- wb_dat_o  out  dw  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry termination.
- wait_cycles  in  4  wait states inserted per access; sampled at request acceptance.
- rty_inject  in  1  when high at acceptance, the access terminates with retry.
- access_count  out  16  count of ack-terminated accesses; saturating.

Behaviour:
- Reset (wb_rst_n low, asynchronous):
  - State goes to IDLE.
  - wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o and access_count go to 0.
  - All register-file words go to 0.
  - All outputs are registered.
- Decode:
  - In-range when (wb_adr_i & ~(4*2**DEPTH_LOG2-1)) == BASE_ADDR.
  - Word index is wb_adr_i[DEPTH_LOG2+1:2]; wb_adr_i[1:0] is ignored.
- State IDLE:
  - On wb_cyc_i & wb_stb_i, latch adr, we, sel, dat, the in-range flag and rty_inject.
  - Load wcnt = wait_cycles.
  - Go to WAIT if wait_cycles != 0, else RESP.
- State WAIT:
  - wcnt decrements each cycle; go to RESP when wcnt == 1.
  - If wb_cyc_i or wb_stb_i is low in any WAIT cycle, abort: return to IDLE, no write, no response, no count.
- Transition into RESP:
  - Exactly one of ack/err/rty is asserted in the RESP cycle, for exactly one cycle.
  - Priority is err (out of range) > rty (latched rty_inject) > ack.
  - On ack-write: the latched word is updated lane-by-lane per latched sel, at the same edge.
  - On ack-read: wb_dat_o = addressed word.
  - On err or rty: wb_dat_o = 0 and no write occurs.
  - access_count += 1 on ack only; it holds at 16'hFFFF.
- State RESP: unconditionally go to IDLE next cycle; wb_dat_o and all terminations return to 0.
- Latency from strobe-sampled edge to termination is 1 + wait_cycles clocks.
  - A held strobe is re-sampled in IDLE as a new access, so back-to-back throughput is one access per 2 + wait_cycles clocks.
- sel = 0 write: acked and counted, no word change.
- Reset asserted mid-access: immediate return to IDLE, outputs cleared, no partial write.
- Changes to wait_cycles or rty_inject after acceptance do not affect the access in flight.

Test Plan:
- Write word index 3 with 32'hDEAD_BEEF, sel 4'hF, wait_cycles 0; then read index 3 -> each access gets one ack cycle 1 clock after strobe; read returns 32'hDEAD_BEEF; access_count = 2.
- Write 32'h1122_3344 with sel 4'b0101 over a word holding 32'hFFFF_FFFF -> read returns 32'hFF22_FF44.
- wait_cycles = 5, read -> ack exactly 6 clocks after strobe; drop wb_stb_i after 3 clocks on a second access -> no ack/err/rty, access_count unchanged, next access behaves normally.
- Access to BASE_ADDR + 0x40 (DEPTH_LOG2 = 4) -> wb_err_o one cycle, wb_dat_o = 0, no write; with rty_inject also high, err still wins.
- rty_inject = 1 on a write of 32'h5A5A_5A5A -> wb_rty_o one cycle, word unchanged, count unchanged; retry with rty_inject = 0 -> ack, word updated.
- Assert wb_rst_n low during WAIT of a write -> all outputs 0 immediately; subsequent read of that word returns 0; access_count = 0.
